// File: rtl/axi_sram_slave.sv
// AXI3 slave memory model: word-addressed 32-bit RAM behind independent read and
// write state machines, one outstanding transaction each, with configurable read latency.
module axi_sram_slave #(
    parameter int ADDR_WIDTH = 16,
    parameter int READ_DELAY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

    localparam logic [3:0] DELAY_LAST  = 4'(READ_DELAY - 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;

    logic [31:0] mem [2**ADDR_WIDTH];

    rstate_t               rstate, rstate_nx;
    wstate_t               wstate, wstate_nx;
    logic                  rst_q;
    logic [ADDR_WIDTH-1:0] r_idx, r_idx_nx, w_idx, w_idx_nx;
    logic [3:0]            r_len, r_beat, r_cnt, w_len, w_beat;
    logic                  r_fixed, r_err, w_fixed, w_err, w_proto;
    logic                  ar_hs, aw_hs, w_hs;
    logic                  unused_inputs;

    function automatic logic [ADDR_WIDTH-1:0] word_index(input logic [31:0] addr);
        return addr[ADDR_WIDTH+1:2];
    endfunction

    // Sizes, protection and lock attributes beyond the index bits carry no meaning here.
    assign unused_inputs = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid,
                             araddr[31:ADDR_WIDTH+2], araddr[1:0], arlen[7:4],
                             awaddr[31:ADDR_WIDTH+2], awaddr[1:0], awlen[7:4]};

    // Holding ready low for the cycle after reset keeps the IDLE state from showing during reset.
    assign arready  = (rstate == R_IDLE) && !rst_q;
    assign awready  = (wstate == W_IDLE) && !rst_q;
    assign rvalid   = (rstate == R_DATA);
    assign rlast    = (rstate == R_DATA) && (r_beat == r_len);
    assign rresp    = r_err ? RESP_SLVERR : RESP_OKAY;
    assign wready   = (wstate == W_DATA);
    assign bvalid   = (wstate == W_RESP);
    assign bresp    = (w_err || w_proto) ? RESP_SLVERR : RESP_OKAY;
    assign ar_hs    = arvalid && arready;
    assign aw_hs    = awvalid && awready;
    assign w_hs     = wvalid && wready;
    assign r_idx_nx = r_fixed ? r_idx : r_idx + ADDR_WIDTH'(1);
    assign w_idx_nx = w_fixed ? w_idx : w_idx + ADDR_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            rstate <= R_IDLE;
            wstate <= W_IDLE;
            rst_q  <= 1'b1;
        end else begin
            rstate <= rstate_nx;
            wstate <= wstate_nx;
            rst_q  <= 1'b0;
        end
    end

    always_comb begin
        rstate_nx = rstate;
        case (rstate)
            R_IDLE:  if (ar_hs) rstate_nx = (READ_DELAY == 0) ? R_DATA : R_WAIT;
            R_WAIT:  if (r_cnt == DELAY_LAST) rstate_nx = R_DATA;
            R_DATA:  if (rready && r_beat == r_len) rstate_nx = R_IDLE;
            default: rstate_nx = R_IDLE;
        endcase
    end

    always_comb begin
        wstate_nx = wstate;
        case (wstate)
            W_IDLE:  if (aw_hs) wstate_nx = W_DATA;
            W_DATA:  if (w_hs && w_beat == w_len) wstate_nx = W_RESP;
            W_RESP:  if (bready) wstate_nx = W_IDLE;
            default: wstate_nx = W_IDLE;
        endcase
    end

    // rdata is fetched on the edge that presents a beat and then held, so a stalled
    // beat and a same-edge write both see the pre-write word.
    always_ff @(posedge clk) begin
        if (reset) begin
            rid     <= '0;
            rdata   <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_cnt   <= '0;
            r_fixed <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (rstate)
                R_IDLE: if (ar_hs) begin
                    rid     <= arid;
                    r_idx   <= word_index(araddr);
                    r_len   <= arlen[3:0];
                    r_fixed <= (arburst == BURST_FIXED);
                    r_err   <= (arsize > 3'd2);
                    r_beat  <= '0;
                    r_cnt   <= '0;
                    if (READ_DELAY == 0)
                        rdata <= (arsize > 3'd2) ? '0 : mem[word_index(araddr)];
                end
                R_WAIT: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == DELAY_LAST)
                        rdata <= r_err ? '0 : mem[r_idx];
                end
                R_DATA: if (rready) begin
                    r_beat <= r_beat + 4'd1;
                    r_idx  <= r_idx_nx;
                    if (r_beat != r_len)
                        rdata <= r_err ? '0 : mem[r_idx_nx];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bid     <= '0;
            w_idx   <= '0;
            w_len   <= '0;
            w_beat  <= '0;
            w_fixed <= 1'b0;
            w_err   <= 1'b0;
            w_proto <= 1'b0;
        end else begin
            case (wstate)
                W_IDLE: if (aw_hs) begin
                    bid     <= awid;
                    w_idx   <= word_index(awaddr);
                    w_len   <= awlen[3:0];
                    w_fixed <= (awburst == BURST_FIXED);
                    w_err   <= (awsize > 3'd2);
                    w_proto <= 1'b0;
                    w_beat  <= '0;
                end
                W_DATA: if (w_hs) begin
                    w_beat <= w_beat + 4'd1;
                    w_idx  <= w_idx_nx;
                    if (wlast != (w_beat == w_len))
                        w_proto <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wstate == W_DATA && w_hs && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b])
                    mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomized and directed bench for axi_sram_slave against a word-array reference
// model that applies the addressing, burst, strobe and response rules directly.
module tb_axi_sram_slave;

    localparam int AW = 16;
    localparam int RD = 2;

    typedef logic [31:0] dvec_t [16];
    typedef logic [3:0]  svec_t [16];

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
    logic [3:0]  arcache, awcache, wstrb;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int errors = 0;
    int checks = 0;
    logic [31:0] model [int unsigned];

    always #5 clk = ~clk;

    axi_sram_slave #(.ADDR_WIDTH(AW), .READ_DELAY(RD)) dut (
        .clk(clk), .reset(reset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned widx(input logic [31:0] addr);
        return (addr >> 2) % (1 << AW);
    endfunction

    function automatic int unsigned step(input int unsigned idx, input logic [1:0] burst);
        return (burst == 2'b00) ? idx : (idx + 1) % (1 << AW);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, 32'({arready, awready, wready, rvalid, bvalid, rlast, rresp, bresp}), 32'h0);
        check({tag, "_rdata"}, rdata, 32'h0);
        check({tag, "_ids"}, 32'({rid, bid}), 32'h0);
    endtask

    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                               input logic [1:0] burst, input logic [2:0] size,
                               input dvec_t d, input svec_t s, input int bad_beat);
        int unsigned idx;
        bit          err, bad;
        int          n;
        logic [31:0] w;
        err = (size > 3'd2);
        bad = 1'b0;
        idx = widx(addr);
        awid = id; awaddr = addr; awlen = {4'($urandom), len}; awsize = size; awburst = burst;
        awlock = 2'($urandom); awcache = 4'($urandom); awprot = 3'($urandom);
        awvalid = 1'b1;
        n = 0;
        while (!awready && n < 100) begin tick; n++; end
        check("aw_wait", 32'(n < 100), 32'h1);
        tick;
        awvalid = 1'b0;
        check("wready_after_aw", 32'(wready), 32'h1);
        for (int b = 0; b <= int'(len); b++) begin
            if ($urandom % 4 == 0) begin wvalid = 1'b0; tick; end
            wvalid = 1'b1; wid = 4'($urandom); wdata = d[b]; wstrb = s[b];
            wlast = (b == int'(len)) ^ (b == bad_beat);
            n = 0;
            while (!wready && n < 100) begin tick; n++; end
            check("w_wait", 32'(n < 100), 32'h1);
            tick;
            if (!err) begin
                w = model.exists(idx) ? model[idx] : 32'h0;
                for (int k = 0; k < 4; k++)
                    if (s[b][k]) w[8*k +: 8] = d[b][8*k +: 8];
                model[idx] = w;
            end
            if (b == bad_beat) bad = 1'b1;
            idx = step(idx, burst);
        end
        wvalid = 1'b0; wlast = 1'b0;
        check("b_resp", 32'({bvalid, bid, bresp}), 32'({1'b1, id, (err || bad) ? 2'b10 : 2'b00}));
        repeat ($urandom % 3) tick;
        check("b_hold", 32'({bvalid, wready}), 32'h2);
        bready = 1'b1;
        tick;
        bready = 1'b0;
        check("b_after", 32'({bvalid, wready, awready}), 32'h1);
    endtask

    task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                              input logic [1:0] burst, input logic [2:0] size, input int mode,
                              output logic [31:0] first, output logic [31:0] last);
        logic [31:0] expq[$];
        int unsigned idx;
        bit          err;
        int          n, beat, cyc;
        err = (size > 3'd2);
        idx = widx(addr);
        for (int b = 0; b <= int'(len); b++) begin
            expq.push_back(err ? 32'h0 : model[idx]);
            idx = step(idx, burst);
        end
        first = 32'h0; last = 32'h0;
        arid = id; araddr = addr; arlen = {4'($urandom), len}; arsize = size; arburst = burst;
        arlock = 2'($urandom); arcache = 4'($urandom); arprot = 3'($urandom);
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 100) begin tick; n++; end
        check("ar_wait", 32'(n < 100), 32'h1);
        tick;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 40) begin tick; n++; end
        check("r_latency", 32'(n), 32'(RD));
        beat = 0; cyc = 0;
        while (beat <= int'(len) && cyc < 400) begin
            case (mode)
                0:       rready = 1'b1;
                1:       rready = (cyc % 2 == 0);
                default: rready = 1'($urandom);
            endcase
            check("r_ctl", 32'({rvalid, rlast, rresp, rid}),
                  32'({1'b1, beat == int'(len), err ? 2'b10 : 2'b00, id}));
            check("r_data", rdata, expq[beat]);
            if (beat == 0) first = rdata;
            last = rdata;
            tick;
            if (rready) beat++;
            cyc++;
        end
        rready = 1'b0;
        check("r_done", 32'(beat == int'(len) + 1), 32'h1);
        check("r_after", 32'({rvalid, arready}), 32'h1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    initial begin
        dvec_t       dv;
        svec_t       sv;
        logic [31:0] f, l;
        int          n;
        reset = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arlock = '0;
        arcache = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awlock = '0;
        awcache = '0; awprot = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        dv = '{default: 32'h0};
        sv = '{default: 4'hF};
        repeat (3) tick;
        check_reset_outputs("reset");
        reset = 1'b0;
        tick;
        check("ready_after_reset", 32'({arready, awready, wready, rvalid, bvalid}), 32'h18);

        // Single write then read
        dv[0] = 32'hDEADBEEF;
        write_burst(4'h5, 32'h1C000000, 4'd0, 2'b01, 3'd2, dv, sv, -1);
        read_burst(4'h3, 32'h1C000000, 4'd0, 2'b01, 3'd2, 0, f, l);
        check("single_rdata", f, 32'hDEADBEEF);

        // INCR burst read back with rready toggling
        dv[0] = 32'h11; dv[1] = 32'h22; dv[2] = 32'h33; dv[3] = 32'h44;
        write_burst(4'h1, 32'h100, 4'd3, 2'b01, 3'd2, dv, sv, -1);
        read_burst(4'h2, 32'h100, 4'd3, 2'b01, 3'd2, 1, f, l);
        check("incr_first", f, 32'h11);
        check("incr_last", l, 32'h44);

        // Byte strobes
        dv[0] = 32'hFFFFFFFF;
        write_burst(4'h6, 32'h180, 4'd0, 2'b01, 3'd2, dv, sv, -1);
        dv[0] = 32'h12345678; sv[0] = 4'b0101;
        write_burst(4'h7, 32'h180, 4'd0, 2'b01, 3'd2, dv, sv, -1);
        sv[0] = 4'hF;
        read_burst(4'h8, 32'h180, 4'd0, 2'b01, 3'd2, 0, f, l);
        check("strobe_merge", f, 32'hFF34FF78);

        // FIXED burst, oversized transfers, bad wlast
        dv[0] = 32'hA; dv[1] = 32'hB; dv[2] = 32'hC;
        write_burst(4'h9, 32'h200, 4'd2, 2'b00, 3'd2, dv, sv, -1);
        read_burst(4'hA, 32'h200, 4'd0, 2'b01, 3'd2, 0, f, l);
        check("fixed_last_wins", f, 32'hC);
        read_burst(4'hB, 32'h200, 4'd0, 2'b01, 3'd3, 0, f, l);
        check("size_err_rdata", f, 32'h0);
        dv[0] = 32'h99;
        write_burst(4'hC, 32'h200, 4'd0, 2'b01, 3'd3, dv, sv, -1);
        read_burst(4'hD, 32'h200, 4'd0, 2'b01, 3'd2, 0, f, l);
        check("size_err_no_write", f, 32'hC);
        dv[0] = 32'h5A5A0001; dv[1] = 32'h5A5A0002;
        write_burst(4'hE, 32'h280, 4'd1, 2'b01, 3'd2, dv, sv, 0);
        read_burst(4'hF, 32'h280, 4'd1, 2'b01, 3'd2, 2, f, l);
        check("bad_wlast_written", l, 32'h5A5A0002);

        // Write lands while a read beat of the same word is stalled
        dv[0] = 32'hAAAA5555;
        write_burst(4'h1, 32'h300, 4'd0, 2'b01, 3'd2, dv, sv, -1);
        arid = 4'h4; araddr = 32'h300; arlen = 8'h0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 100) begin tick; n++; end
        tick;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 40) begin tick; n++; end
        check("stall_rvalid", 32'(rvalid), 32'h1);
        dv[0] = 32'h5555AAAA;
        write_burst(4'h2, 32'h300, 4'd0, 2'b01, 3'd2, dv, sv, -1);
        check("stall_old_data", rdata, 32'hAAAA5555);
        check("stall_still_valid", 32'({rvalid, rlast, rid}), 32'h34);
        rready = 1'b1;
        tick;
        rready = 1'b0;
        check("stall_done", 32'({rvalid, arready}), 32'h1);
        read_burst(4'h5, 32'h300, 4'd0, 2'b01, 3'd2, 0, f, l);
        check("stall_new_data", f, 32'h5555AAAA);

        // Index wraps from the last word to word 0
        dv[0] = 32'hCAFE0001; dv[1] = 32'hCAFE0002;
        write_burst(4'h3, 32'h0003FFFC, 4'd1, 2'b01, 3'd2, dv, sv, -1);
        read_burst(4'h6, 32'h0003FFFC, 4'd1, 2'b01, 3'd2, 0, f, l);
        check("wrap_first", f, 32'hCAFE0001);
        check("wrap_second", l, 32'hCAFE0002);

        // Prefill the random-traffic region 0x1000..0x10FF
        for (int blk = 0; blk < 16; blk++) begin
            for (int b = 0; b < 16; b++) dv[b] = $urandom;
            write_burst(4'($urandom), 32'h4000 + 32'(blk * 64), 4'd15, 2'b01, 3'd2, dv, sv, -1);
        end

        // Reset during beat 2 of an 8-beat read
        arid = 4'h2; araddr = 32'h4000; arlen = 8'h7; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 100) begin tick; n++; end
        tick;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 40) begin tick; n++; end
        rready = 1'b1;
        tick;
        tick;
        check("pre_reset_beat", rdata, model[32'h1002]);
        reset = 1'b1;
        rready = 1'b0;
        tick;
        check_reset_outputs("midburst");
        tick;
        reset = 1'b0;
        tick;
        check("post_reset_ready", 32'({arready, awready, rvalid}), 32'h6);
        read_burst(4'h9, 32'h4000, 4'd7, 2'b01, 3'd2, 2, f, l);

        // Random traffic
        for (int it = 0; it < 40; it++) begin
            logic [15:0] idx;
            logic [3:0]  len;
            logic [1:0]  burst;
            logic [2:0]  size;
            logic [31:0] addr;
            int          bad;
            idx   = 16'h1000 + 16'($urandom % 16'hF0);
            len   = 4'($urandom);
            burst = 2'($urandom % 3);
            size  = ($urandom % 6 == 0) ? 3'd3 : 3'($urandom % 3);
            addr  = {14'($urandom), idx, 2'($urandom)};
            if (it % 2 == 1) begin
                for (int b = 0; b < 16; b++) begin dv[b] = $urandom; sv[b] = 4'($urandom); end
                bad = ($urandom % 8 == 0) ? int'($urandom % (int'(len) + 1)) : -1;
                write_burst(4'($urandom), addr, len, burst, size, dv, sv, bad);
            end else begin
                read_burst(4'($urandom), addr, len, burst, size, int'($urandom % 3), f, l);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
